// File: rtl/bus_mem_model.sv
`default_nettype none
// ============================================================================
// Module   : bus_mem_model
// Brief    : Pipelined bench memory responder with LFSR-driven grant/response
//            wait states and an in-order response FIFO.
//            Define BUS_MEM_ERR_INJ_EN to enable the error address window.
// Revision : 1.0
// ============================================================================
module bus_mem_model #(
  parameter int unsigned MEM_AW      = 14,
  parameter int unsigned MEM_DW      = 32,
  parameter int unsigned OUTSTANDING = 4,
  parameter int unsigned GNT_WMAX    = 2,
  parameter int unsigned RESP_WMAX   = 2,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter logic [31:0] ERR_BASE    = 32'h2100_0000,
  parameter logic [31:0] ERR_MASK    = 32'hFFFF_F000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [3:0]        data_be,
  input  logic [31:0]       data_addr,
  input  logic [MEM_DW-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic [MEM_DW-1:0] data_rdata,
  output logic              data_err
);

  localparam int unsigned PW        = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CW        = $clog2(OUTSTANDING + 1);
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [7:0]  GNT_MOD   = 8'(GNT_WMAX + 1);
  localparam logic [7:0]  RESP_MOD  = 8'(RESP_WMAX + 1);
  localparam logic [7:0]  GCNT_RST  = LFSR_SEED[7:0] % GNT_MOD;

  logic [MEM_DW-1:0] mem_q       [2**MEM_AW];
  logic [MEM_DW-1:0] fifo_data_q [OUTSTANDING];

  logic [15:0]       lfsr_q, lfsr_d;
  logic [7:0]        gcnt_q, gcnt_d;
  logic [7:0]        rcnt_q, rcnt_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic [MEM_AW-1:0] word_idx;
  logic              fifo_empty, fifo_full;
  logic              push, pop, head_load, mem_wr, in_err_win;
  logic [7:0]        gnt_load, resp_load;
  logic [31:0]       merged_lo;
  logic [MEM_DW-1:0] merged;
  logic [MEM_DW-1:0] push_data;
  logic              unused_addr_bits;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  assign word_idx         = data_addr[MEM_AW+1:2];
  assign unused_addr_bits = ^{data_addr[31:MEM_AW+2], data_addr[1:0]};

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(OUTSTANDING));
  // A full FIFO still accepts a request when the head leaves in the same cycle.
  assign pop        = !fifo_empty && (rcnt_q == 8'd0);
  assign push       = data_req && (gcnt_q == 8'd0) && (!fifo_full || pop);
  assign head_load  = (push && fifo_empty) || (pop && ((count_q > CW'(1)) || push));

  assign gnt_load   = lfsr_q[7:0] % GNT_MOD;
  assign resp_load  = lfsr_q[15:8] % RESP_MOD;

  assign data_gnt    = push;
  assign data_rvalid = pop;
  assign data_rdata  = pop ? fifo_data_q[rd_ptr_q] : '0;

`ifdef BUS_MEM_ERR_INJ_EN
  logic fifo_err_q [OUTSTANDING];

  assign in_err_win = ((data_addr & ERR_MASK) == (ERR_BASE & ERR_MASK));
  assign data_err   = pop && fifo_err_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push) fifo_err_q[wr_ptr_q] <= in_err_win;
  end
`else
  logic unused_err_cfg;

  assign in_err_win     = 1'b0;
  assign data_err       = 1'b0;
  assign unused_err_cfg = ^{ERR_BASE, ERR_MASK};
`endif

  always_comb begin
    merged_lo = mem_q[word_idx][31:0];
    for (int b = 0; b < 4; b++) begin
      if (data_be[b]) merged_lo[8*b +: 8] = data_wdata[8*b +: 8];
    end
  end

  // Partial writes invalidate the capability tag; full-word writes carry it.
  generate
    if (MEM_DW > 32) begin : g_tag
      assign merged = {(data_be == 4'hF) ? data_wdata[MEM_DW-1] : 1'b0, merged_lo};
    end else begin : g_notag
      assign merged = merged_lo;
    end
  endgenerate

  assign mem_wr    = push && data_we && !in_err_win && (data_be != 4'h0);
  assign push_data = (data_we || in_err_win) ? '0 : mem_q[word_idx];

  always_ff @(posedge clk_i) begin
    if (mem_wr) mem_q[word_idx] <= merged;
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_data_q[wr_ptr_q] <= push_data;
  end

  always_comb begin
    lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);

    gcnt_d = gcnt_q;
    if (push)                              gcnt_d = gnt_load;
    else if (data_req && gcnt_q != 8'd0)   gcnt_d = gcnt_q - 8'd1;

    rcnt_d = rcnt_q;
    if (head_load)                         rcnt_d = resp_load;
    else if (rcnt_q != 8'd0)               rcnt_d = rcnt_q - 8'd1;

    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q   <= LFSR_SEED;
      gcnt_q   <= GCNT_RST;
      rcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      lfsr_q   <= lfsr_d;
      gcnt_q   <= gcnt_d;
      rcnt_q   <= rcnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_mem_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_mem_model
// Brief    : Self-checking bench for bus_mem_model: directed vector table,
//            back-pressure and reset sequences, randomized traffic vs a model.
// Revision : 1.0
// ============================================================================
module tb_bus_mem_model;

  localparam int          AW   = 8;
  localparam int          DW   = 33;
  localparam int          OUTS = 2;
  localparam int          GW   = 2;
  localparam int          RW   = 2;
  localparam logic [15:0] SEED = 16'hACE1;
`ifdef BUS_MEM_ERR_INJ_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          data_req = 1'b0;
  logic          data_we = 1'b0;
  logic [3:0]    data_be = 4'h0;
  logic [31:0]   data_addr = '0;
  logic [DW-1:0] data_wdata = '0;
  logic          data_gnt, data_rvalid, data_err;
  logic [DW-1:0] data_rdata;

  always #5 clk_i = ~clk_i;

  bus_mem_model #(
    .MEM_AW(AW), .MEM_DW(DW), .OUTSTANDING(OUTS),
    .GNT_WMAX(GW), .RESP_WMAX(RW), .LFSR_SEED(SEED)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .data_req(data_req), .data_we(data_we), .data_be(data_be),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata), .data_err(data_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [32:0] d; logic e; } rsp_t;
  rsp_t        mq[$];
  rsp_t        seen[$];
  logic [32:0] mem_m [int];
  int unsigned m_lfsr, m_gcnt, m_rcnt;
  int          outst;

  function automatic bit in_window(input logic [31:0] a);
    return ERR_ON && ((a & 32'hFFFF_F000) == 32'h2100_0000);
  endfunction

  function automatic void mem_write(input int idx, input logic [3:0] be, input logic [32:0] wd);
    logic [32:0] w;
    if (be == 4'h0) return;
    w = mem_m.exists(idx) ? mem_m[idx] : 33'h0;
    if (be == 4'hF) w = wd;
    else begin
      for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
      w[32] = 1'b0;
    end
    mem_m[idx] = w;
  endfunction

  always @(negedge clk_i) begin : mon
    bit   e_pop, e_gnt, new_head;
    int   n, idx, after;
    rsp_t r;
    if (!rst_ni) begin
      mq.delete();
      m_lfsr = SEED;
      m_gcnt = (SEED & 16'h00FF) % (GW + 1);
      m_rcnt = 0;
      outst  = 0;
      chk("reset_rvalid", data_rvalid, 0);
      chk("reset_rdata",  data_rdata, 0);
      chk("reset_err",    data_err, 0);
      chk("reset_gnt",    data_gnt, 0);
    end else begin
      n     = mq.size();
      e_pop = (n > 0) && (m_rcnt == 0);
      e_gnt = data_req && (m_gcnt == 0) && ((n < OUTS) || e_pop);
      chk("gnt",    data_gnt, e_gnt);
      chk("rvalid", data_rvalid, e_pop);
      chk("rdata",  data_rdata, e_pop ? mq[0].d : 33'h0);
      chk("err",    data_err, e_pop ? mq[0].e : 1'b0);
      if (data_rvalid) seen.push_back('{data_rdata, data_err});
      after = outst + (data_gnt ? 1 : 0) - (data_rvalid ? 1 : 0);
      if (data_gnt) chk("outstanding_within_depth", after <= OUTS, 1);
      outst = after;

      if (e_pop) void'(mq.pop_front());
      if (e_gnt) begin
        idx = int'(data_addr[AW+1:2]);
        r.d = 33'h0;
        r.e = in_window(data_addr);
        if (!r.e) begin
          if (data_we) mem_write(idx, data_be, data_wdata);
          else         r.d = mem_m.exists(idx) ? mem_m[idx] : 33'h0;
        end
        mq.push_back(r);
      end
      new_head = (e_gnt && n == 0) || (e_pop && (n > 1 || e_gnt));
      if (new_head)        m_rcnt = ((m_lfsr >> 8) & 255) % (RW + 1);
      else if (m_rcnt > 0) m_rcnt--;
      if (e_gnt)                       m_gcnt = (m_lfsr & 255) % (GW + 1);
      else if (data_req && m_gcnt > 0) m_gcnt--;
      m_lfsr = (m_lfsr & 1) ? ((m_lfsr >> 1) ^ 32'hB400) : (m_lfsr >> 1);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [32:0] wd);
    int   w;
    logic g;
    data_req = 1'b1; data_we = we; data_be = be; data_addr = addr; data_wdata = wd;
    w = 0; g = 1'b0;
    while (!g && w < 100) begin
      @(negedge clk_i); g = data_gnt;
      @(posedge clk_i); #1; w++;
    end
    if (!g) begin
      checks++; errors++;
      $display("FAIL gnt_timeout: no grant after %0d cycles, expected a grant", w);
      finish_run();
    end
  endtask

  task automatic idle(input int n);
    data_req = 1'b0;
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic wait_rsp(input int target, input string name);
    int w = 0;
    while (seen.size() < target && w < 50) begin @(posedge clk_i); #1; w++; end
    chk(name, seen.size() >= target, 1);
  endtask

  task automatic drain();
    int w = 0;
    data_req = 1'b0;
    while (mq.size() > 0 && w < 100) begin @(posedge clk_i); #1; w++; end
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [32:0] wdata;
    logic [32:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];

  initial begin : watchdog
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int          n0;
    logic [32:0] expv [4];

    vecs[0]  = '{1'b1, 4'hF, 32'h8000_0010, 33'h0_1234_5678, 33'h0, 1'b0};
    vecs[1]  = '{1'b0, 4'hF, 32'h8000_0010, 33'h0,           33'h0_1234_5678, 1'b0};
    vecs[2]  = '{1'b0, 4'hF, 32'h0000_0010, 33'h0,           33'h0_1234_5678, 1'b0};
    vecs[3]  = '{1'b1, 4'hF, 32'h0000_0020, 33'h1_DEAD_BEEF, 33'h0, 1'b0};
    vecs[4]  = '{1'b0, 4'hF, 32'h0000_0020, 33'h0,           33'h1_DEAD_BEEF, 1'b0};
    vecs[5]  = '{1'b1, 4'h2, 32'h0000_0020, 33'h1_0000_AA00, 33'h0, 1'b0};
    vecs[6]  = '{1'b0, 4'hF, 32'h0000_0020, 33'h0,           33'h0_DEAD_AAEF, 1'b0};
    vecs[7]  = '{1'b1, 4'h0, 32'h0000_0020, 33'h1_FFFF_FFFF, 33'h0, 1'b0};
    vecs[8]  = '{1'b0, 4'hF, 32'h0000_0020, 33'h0,           33'h0_DEAD_AAEF, 1'b0};
    vecs[9]  = '{1'b1, 4'hF, 32'h0000_0200, 33'h0_CAFE_F00D, 33'h0, 1'b0};
    vecs[10] = '{1'b0, 4'hF, 32'h2100_0600, 33'h0,
                 ERR_ON ? 33'h0 : 33'h0_CAFE_F00D, ERR_ON};
    vecs[11] = '{1'b1, 4'hF, 32'h2100_0600, 33'h0_1111_1111, 33'h0, ERR_ON};
    vecs[12] = '{1'b0, 4'hF, 32'h0000_0200, 33'h0,
                 ERR_ON ? 33'h0_CAFE_F00D : 33'h0_1111_1111, 1'b0};

    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Give every word a defined value so reads have a known expectation.
    for (int i = 0; i < 2**AW; i++)
      issue(1'b1, 4'hF, 32'h8000_0000 | (i << 2), {1'($urandom_range(0, 1)), 32'($urandom)});
    drain();

    for (int i = 0; i < 13; i++) begin
      n0 = seen.size();
      issue(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata);
      data_req = 1'b0;
      wait_rsp(n0 + 1, $sformatf("vec%0d_response", i));
      if (seen.size() > n0) begin
        chk($sformatf("vec%0d_rdata", i), seen[n0].d, vecs[i].exp_rdata);
        chk($sformatf("vec%0d_err", i),   seen[n0].e, vecs[i].exp_err);
      end
    end
    drain();

    // Back-pressure: four back-to-back reads through a two-entry FIFO.
    for (int k = 0; k < 4; k++) expv[k] = mem_m[40 + k];
    n0 = seen.size();
    for (int k = 0; k < 4; k++) issue(1'b0, 4'hF, (40 + k) << 2, 33'h0);
    data_req = 1'b0;
    wait_rsp(n0 + 4, "backpressure_responses");
    if (seen.size() >= n0 + 4)
      for (int k = 0; k < 4; k++) chk($sformatf("backpressure_order%0d", k), seen[n0 + k].d, expv[k]);
    drain();

    for (int i = 0; i < 1000; i++) begin
      logic [3:0] be;
      int         sel;
      sel = $urandom_range(0, 3);
      be  = (sel == 0) ? 4'hF : (sel == 1) ? 4'h0 : 4'($urandom);
      idle($urandom_range(0, 1));
      issue(1'($urandom_range(0, 1)), be, 32'($urandom),
            {1'($urandom_range(0, 1)), 32'($urandom)});
    end
    drain();

    // Reset while responses are still pending.
    for (int k = 0; k < 3; k++) issue(1'b0, 4'hF, k << 2, 33'h0);
    data_req = 1'b0;
    #1 rst_ni = 1'b0;
    #1 chk("reset_async_rvalid", data_rvalid, 0);
    chk("reset_async_rdata", data_rdata, 0);
    @(posedge clk_i); #2 rst_ni = 1'b1;
    n0 = seen.size();
    repeat (20) @(posedge clk_i);
    #1 chk("no_stale_response", seen.size(), n0);

    expv[0] = mem_m[5];
    issue(1'b0, 4'hF, 32'h0000_0014, 33'h0);
    data_req = 1'b0;
    wait_rsp(n0 + 1, "post_reset_response");
    if (seen.size() > n0) chk("post_reset_rdata", seen[n0].d, expv[0]);
    drain();

    finish_run();
  end

endmodule
`default_nettype wire
